// File: rtl/hs_pkg.sv
// Shared handshake definitions: receiver FSM states and the word width agreed with the sender.
package hs_pkg;

  localparam int unsigned HS_WIDTH = 6;

  typedef enum logic {
    HS_IDLE = 1'b0,
    HS_ACK  = 1'b1
  } hs_state_e;

endpackage : hs_pkg

// File: rtl/hs_fifo.sv
// First-word fall-through FIFO; the head word is visible on rd_data with no read latency.
module hs_fifo
  import hs_pkg::*;
#(
  parameter int unsigned WIDTH = HS_WIDTH,
  parameter int unsigned DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       clr,
  input  logic                       i_push,
  input  logic [WIDTH-1:0]           i_push_data,
  input  logic                       i_rd_ready,
  output logic                       o_full,
  output logic [WIDTH-1:0]           o_rd_data,
  output logic                       o_rd_valid,
  output logic [$clog2(DEPTH+1)-1:0] o_count
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PW-1:0]    r_wr_ptr;
  logic [PW-1:0]    r_rd_ptr;
  logic [CW-1:0]    r_count;
  logic             w_push_ok;
  logic             w_pop_ok;

  // Full is judged on the pre-pop count, so a same-cycle pop never frees a slot early.
  assign o_full     = (r_count == CW'(DEPTH));
  assign o_rd_valid = (r_count != '0);
  assign o_rd_data  = r_mem[r_rd_ptr];
  assign o_count    = r_count;
  assign w_push_ok  = i_push && !o_full;
  assign w_pop_ok   = i_rd_ready && o_rd_valid;

  always_ff @(posedge clk) begin
    if (clr) begin
      for (int i = 0; i < int'(DEPTH); i++) r_mem[i] <= '0;
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push_ok) begin
        r_mem[r_wr_ptr] <= i_push_data;
        r_wr_ptr        <= r_wr_ptr + PW'(1);
      end
      if (w_pop_ok) r_rd_ptr <= r_rd_ptr + PW'(1);
      case ({w_push_ok, w_pop_ok})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule : hs_fifo

// File: rtl/hs_receiver.sv
// Four-phase req/ack receiver: synchronises req, pushes one word per handshake into a FIFO,
// and offers buffered words downstream on a valid/ready port.
module hs_receiver
  import hs_pkg::*;
#(
  parameter int unsigned WIDTH       = HS_WIDTH,
  parameter int unsigned DEPTH       = 4,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic                       clk,
  input  logic                       clr,
  input  logic                       req,
  input  logic [WIDTH-1:0]           data_in,
  output logic                       ack,
  output logic                       complete,
  output logic [WIDTH-1:0]           rd_data,
  output logic                       rd_valid,
  input  logic                       rd_ready,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  hs_state_e r_state;
  hs_state_e w_state_nxt;
  logic      w_req_s;
  logic      w_push;
  logic      w_full;

  // req crosses from the sender's domain; SYNC_STAGES=0 trusts it as already synchronous.
  if (SYNC_STAGES == 0) begin : g_no_sync
    assign w_req_s = req;
  end else begin : g_sync
    logic [SYNC_STAGES-1:0] r_sync;
    always_ff @(posedge clk) begin
      if (clr) begin
        r_sync <= '0;
      end else begin
        r_sync[0] <= req;
        for (int i = 1; i < int'(SYNC_STAGES); i++) r_sync[i] <= r_sync[i-1];
      end
    end
    assign w_req_s = r_sync[SYNC_STAGES-1];
  end

  always_ff @(posedge clk) begin
    if (clr) r_state <= HS_IDLE;
    else     r_state <= w_state_nxt;
  end

  // Push only on the IDLE->ACK transition so each handshake stores exactly one word.
  always_comb begin
    w_state_nxt = r_state;
    w_push      = 1'b0;
    case (r_state)
      HS_IDLE: begin
        if (w_req_s && !w_full) begin
          w_push      = 1'b1;
          w_state_nxt = HS_ACK;
        end
      end
      HS_ACK: begin
        if (!w_req_s) w_state_nxt = HS_IDLE;
      end
      default: w_state_nxt = HS_IDLE;
    endcase
  end

  assign ack      = (r_state == HS_ACK);
  assign complete = (r_state == HS_IDLE) && !w_full;

  hs_fifo #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk         (clk),
    .clr         (clr),
    .i_push      (w_push),
    .i_push_data (data_in),
    .i_rd_ready  (rd_ready),
    .o_full      (w_full),
    .o_rd_data   (rd_data),
    .o_rd_valid  (rd_valid),
    .o_count     (count)
  );

endmodule : hs_receiver

// File: tb/tb_hs_receiver.sv
// Directed bench for hs_receiver: reset, handshake latency, full stall, ordering/wrap,
// concurrent push/pop and mid-handshake reset.
module tb_hs_receiver;

  logic       clk = 1'b0;
  logic       clr;
  logic       req;
  logic [5:0] data_in;
  logic       ack;
  logic       complete;
  logic [5:0] rd_data;
  logic       rd_valid;
  logic       rd_ready;
  logic [2:0] count;

  int n_chk = 0;
  int n_bad = 0;

  logic       mon_en = 1'b0;
  logic [5:0] mon_q[$];

  always #5 clk = ~clk;

  hs_receiver #(
    .WIDTH       (6),
    .DEPTH       (4),
    .SYNC_STAGES (2)
  ) dut (
    .clk      (clk),
    .clr      (clr),
    .req      (req),
    .data_in  (data_in),
    .ack      (ack),
    .complete (complete),
    .rd_data  (rd_data),
    .rd_valid (rd_valid),
    .rd_ready (rd_ready),
    .count    (count)
  );

  // Capture words as they are popped; negedge sits between edges so values are settled.
  always @(negedge clk) begin
    if (mon_en && rd_valid && rd_ready) mon_q.push_back(rd_data);
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Full four-phase handshake; both edges must take exactly SYNC_STAGES+1 = 3 clocks.
  task automatic send(input logic [5:0] d, input string tag);
    int n;
    data_in = d;
    req     = 1'b1;
    n       = 0;
    do begin tick(); n++; end while (!ack && n < 20);
    chk({tag, "_ack_lat"}, 32'(n), 32'd3);
    req     = 1'b0;
    data_in = ~d;
    n       = 0;
    do begin tick(); n++; end while (ack && n < 20);
    chk({tag, "_rel_lat"}, 32'(n), 32'd3);
  endtask

  task automatic pop_chk(input logic [5:0] exp, input string tag);
    chk({tag, "_valid"}, 32'(rd_valid), 32'd1);
    chk({tag, "_data"}, 32'(rd_data), 32'(exp));
    rd_ready = 1'b1;
    tick();
    rd_ready = 1'b0;
  endtask

  initial begin
    int n;
    clr      = 1'b1;
    req      = 1'b1;
    data_in  = 6'h00;
    rd_ready = 1'b0;

    // 1. reset held with req high
    tick();
    tick();
    chk("rst_ack", 32'(ack), 32'd0);
    chk("rst_valid", 32'(rd_valid), 32'd0);
    chk("rst_count", 32'(count), 32'd0);
    chk("rst_data", 32'(rd_data), 32'd0);
    clr = 1'b0;
    req = 1'b0;
    tick();
    chk("rst_complete", 32'(complete), 32'd1);
    tick();
    tick();
    chk("rst_no_push", 32'(count), 32'd0);

    // 2. single word, step by step
    data_in = 6'h2A;
    req     = 1'b1;
    tick();
    tick();
    chk("t2_ack_early", 32'(ack), 32'd0);
    tick();
    chk("t2_ack_rise", 32'(ack), 32'd1);
    chk("t2_data", 32'(rd_data), 32'h2A);
    chk("t2_valid", 32'(rd_valid), 32'd1);
    chk("t2_count", 32'(count), 32'd1);
    chk("t2_complete_busy", 32'(complete), 32'd0);
    req     = 1'b0;
    data_in = 6'h15;
    tick();
    tick();
    chk("t2_ack_hold", 32'(ack), 32'd1);
    tick();
    chk("t2_ack_fall", 32'(ack), 32'd0);
    chk("t2_count_once", 32'(count), 32'd1);
    chk("t2_data_kept", 32'(rd_data), 32'h2A);
    pop_chk(6'h2A, "t2_pop");
    chk("t2_empty", 32'(count), 32'd0);

    // 3. fill, stall, then release one slot
    send(6'h01, "t3_w1");
    send(6'h02, "t3_w2");
    send(6'h03, "t3_w3");
    send(6'h04, "t3_w4");
    chk("t3_count_full", 32'(count), 32'd4);
    chk("t3_complete_full", 32'(complete), 32'd0);
    data_in = 6'h05;
    req     = 1'b1;
    for (int i = 0; i < 6; i++) tick();
    chk("t3_stall_ack", 32'(ack), 32'd0);
    chk("t3_stall_count", 32'(count), 32'd4);
    chk("t3_head", 32'(rd_data), 32'h01);
    rd_ready = 1'b1;
    tick();
    rd_ready = 1'b0;
    chk("t3_pop_no_push", 32'(count), 32'd3);
    chk("t3_pop_ack", 32'(ack), 32'd0);
    tick();
    chk("t3_late_ack", 32'(ack), 32'd1);
    chk("t3_late_count", 32'(count), 32'd4);
    chk("t3_new_head", 32'(rd_data), 32'h02);
    req = 1'b0;
    n   = 0;
    do begin tick(); n++; end while (ack && n < 20);
    chk("t3_rel_lat", 32'(n), 32'd3);
    pop_chk(6'h02, "t3_d2");
    pop_chk(6'h03, "t3_d3");
    pop_chk(6'h04, "t3_d4");
    pop_chk(6'h05, "t3_d5");
    chk("t3_drained", 32'(rd_valid), 32'd0);

    // 4. streaming order across two pointer wraps
    mon_q.delete();
    mon_en   = 1'b1;
    rd_ready = 1'b1;
    for (int i = 0; i < 10; i++) send(6'(8'h10 + i), "t4_w");
    tick();
    tick();
    mon_en   = 1'b0;
    rd_ready = 1'b0;
    chk("t4_n_words", 32'(mon_q.size()), 32'd10);
    for (int i = 0; i < 10; i++) begin
      if (i < mon_q.size()) chk("t4_order", 32'(mon_q[i]), 32'(8'h10 + i));
    end
    chk("t4_empty", 32'(count), 32'd0);

    // 5. push and pop on the same edge at count=2
    send(6'h21, "t5_w1");
    send(6'h22, "t5_w2");
    chk("t5_pre_count", 32'(count), 32'd2);
    data_in = 6'h23;
    req     = 1'b1;
    tick();
    tick();
    rd_ready = 1'b1;
    tick();
    rd_ready = 1'b0;
    chk("t5_ack", 32'(ack), 32'd1);
    chk("t5_count", 32'(count), 32'd2);
    chk("t5_head", 32'(rd_data), 32'h22);
    req = 1'b0;
    n   = 0;
    do begin tick(); n++; end while (ack && n < 20);
    chk("t5_rel_lat", 32'(n), 32'd3);
    pop_chk(6'h22, "t5_d2");
    pop_chk(6'h23, "t5_d3");

    // 6. reset in ACK with three words buffered
    send(6'h31, "t6_w1");
    send(6'h32, "t6_w2");
    data_in = 6'h33;
    req     = 1'b1;
    n       = 0;
    do begin tick(); n++; end while (!ack && n < 20);
    chk("t6_ack_lat", 32'(n), 32'd3);
    chk("t6_pre_count", 32'(count), 32'd3);
    clr = 1'b1;
    tick();
    chk("t6_ack", 32'(ack), 32'd0);
    chk("t6_count", 32'(count), 32'd0);
    chk("t6_valid", 32'(rd_valid), 32'd0);
    clr = 1'b0;
    req = 1'b0;
    tick();
    tick();
    tick();
    chk("t6_idle_count", 32'(count), 32'd0);
    send(6'h3F, "t6_new");
    chk("t6_new_count", 32'(count), 32'd1);
    chk("t6_new_data", 32'(rd_data), 32'h3F);
    chk("t6_complete", 32'(complete), 32'd1);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

endmodule : tb_hs_receiver
